// File: rtl/instr_decoder_pipe.sv
// ---------------------------------------------------------------------------
// instr_decoder_pipe
//   Instruction buffer (small FIFO) feeding a decode register, with the
//   control decodes for load / mov / ALU / jump / NOP instructions
//   registered alongside the decode register.
//
//   Instruction classes (ir):
//     load : ir[7]   == 0    destination code ir[6:4]
//     mov  : ir[7:6] == 10   destination ir[5:3], source ir[2:0]
//     alu  : ir[7:5] == 110  x_sel = ir[4], y_sel = ir[3]
//     jmp  : ir[7:4] == 1110, jmp_nz : ir[7:4] == 1111
//
// Ports
//   clk, sync_reset      clock, asynchronous active-high reset
//   instr_in/_valid      push side; instr_ready = buffer not full
//   stall                hold the decode register (pushes continue)
//   flush                empty buffer, clear dec_valid, drop coincident push
//   x0, y0               jump-address operands
//   dec_valid, ir        decode register and its live flag
//   ir_nibble            ir[3:0] zero-extended to DW
//   jmp_addr_big         {ir[1:0], y0, x0}
//   jmp, jmp_nz, i_sel, x_sel, y_sel, source_sel, reg_en, nop_flags
//                        decoded controls (idle values when dec_valid = 0)
//   fifo_count           buffer occupancy
//   dbg_reg_en           reg_en[7:0] mirror when ID_DEBUG_EN is defined,
//                        otherwise tied to zero
//
// Build option: define ID_DEBUG_EN to enable the dbg_reg_en mirror.
// ---------------------------------------------------------------------------
module instr_decoder_pipe #(
    parameter int DW         = 4,
    parameter int IBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          sync_reset,
    input  logic [7:0]                    instr_in,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [DW-1:0]                 x0,
    input  logic [DW-1:0]                 y0,
    output logic                          dec_valid,
    output logic [7:0]                    ir,
    output logic [DW-1:0]                 ir_nibble,
    output logic [2*DW+1:0]               jmp_addr_big,
    output logic                          jmp,
    output logic                          jmp_nz,
    output logic                          i_sel,
    output logic                          x_sel,
    output logic                          y_sel,
    output logic [3:0]                    source_sel,
    output logic [8:0]                    reg_en,
    output logic [3:0]                    nop_flags,
    output logic [$clog2(IBUF_DEPTH):0]   fifo_count,
    output logic [7:0]                    dbg_reg_en
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;

    // ---------------- instruction buffer ----------------
    logic [7:0]    mem [IBUF_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push, pop;

    // Ready comes from the registered count only, so a full buffer refuses
    // a push even in a cycle where it also pops.
    assign instr_ready = (count_reg < CW'(IBUF_DEPTH));
    assign push        = instr_valid && instr_ready && !flush;
    assign pop         = !stall && !flush && (count_reg != '0);
    assign fifo_count  = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= instr_in;
        end
    end

    // Pointers are power-of-two sized, so plain increment wraps modulo depth.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- decode register ----------------
    logic [7:0] ir_reg, ir_next;
    logic       dec_valid_reg, dec_valid_next;

    always_comb begin
        ir_next        = ir_reg;
        dec_valid_next = dec_valid_reg;
        if (flush) begin
            dec_valid_next = 1'b0;
        end else if (!stall) begin
            if (count_reg != '0) begin
                ir_next        = mem[rd_ptr_reg];
                dec_valid_next = 1'b1;
            end else begin
                dec_valid_next = 1'b0;
            end
        end
    end

    // ---------------- decodes of the next decode-register value ----------------
    logic       is_load, is_mov, is_alu, wr_op;
    logic [2:0] dst, src;
    logic [7:0] dst_hit;

    always_comb begin
        is_load = dec_valid_next && !ir_next[7];
        is_mov  = dec_valid_next && (ir_next[7:6] == 2'b10);
        is_alu  = dec_valid_next && (ir_next[7:5] == 3'b110);
        wr_op   = is_load || is_mov;
        dst     = is_load ? ir_next[6:4] : ir_next[5:3];
        src     = ir_next[2:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dst_hit
            assign dst_hit[gi] = wr_op && (dst == 3'(gi));
        end
    endgenerate

    logic [8:0] reg_en_next;
    logic [3:0] source_sel_next, nop_next;
    logic       jmp_next, jmp_nz_next, i_sel_next, x_sel_next, y_sel_next;

    always_comb begin
        // Bit 8 is o_reg (destination code 4); bit 6 also fires when a mov
        // reads source 7.
        reg_en_next = {dst_hit[4], dst_hit[7],
                       dst_hit[6] | dst_hit[7] | (is_mov && (src == 3'd7)),
                       dst_hit[5], is_alu, dst_hit[3:0]};

        if (!dec_valid_next)                          source_sel_next = 4'd10;
        else if (is_load)                             source_sel_next = 4'd8;
        else if (is_mov && src == dst && dst == 3'd4) source_sel_next = 4'd4;
        else if (is_mov && src == dst)                source_sel_next = 4'd9;
        else                                          source_sel_next = {1'b0, src};

        i_sel_next  = dec_valid_next && !(wr_op && dst == 3'd6);
        jmp_next    = dec_valid_next && (ir_next[7:4] == 4'hE);
        jmp_nz_next = dec_valid_next && (ir_next[7:4] == 4'hF);
        x_sel_next  = is_alu && ir_next[4];
        y_sel_next  = is_alu && ir_next[3];
        nop_next    = {dec_valid_next && ir_next == 8'hDF,
                       dec_valid_next && ir_next == 8'hD8,
                       dec_valid_next && ir_next == 8'hCF,
                       dec_valid_next && ir_next == 8'hC8};
    end

    logic [8:0] reg_en_reg;
    logic [3:0] source_sel_reg, nop_reg;
    logic       jmp_reg, jmp_nz_reg, i_sel_reg, x_sel_reg, y_sel_reg;

    // Reset forces every register enable on (reg_en = 1FF) until release.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            ir_reg         <= 8'h00;
            dec_valid_reg  <= 1'b0;
            reg_en_reg     <= 9'h1FF;
            source_sel_reg <= 4'd10;
            nop_reg        <= 4'h0;
            jmp_reg        <= 1'b0;
            jmp_nz_reg     <= 1'b0;
            i_sel_reg      <= 1'b0;
            x_sel_reg      <= 1'b0;
            y_sel_reg      <= 1'b0;
        end else begin
            ir_reg         <= ir_next;
            dec_valid_reg  <= dec_valid_next;
            reg_en_reg     <= reg_en_next;
            source_sel_reg <= source_sel_next;
            nop_reg        <= nop_next;
            jmp_reg        <= jmp_next;
            jmp_nz_reg     <= jmp_nz_next;
            i_sel_reg      <= i_sel_next;
            x_sel_reg      <= x_sel_next;
            y_sel_reg      <= y_sel_next;
        end
    end

    assign ir           = ir_reg;
    assign dec_valid    = dec_valid_reg;
    assign reg_en       = reg_en_reg;
    assign source_sel   = source_sel_reg;
    assign nop_flags    = nop_reg;
    assign jmp          = jmp_reg;
    assign jmp_nz       = jmp_nz_reg;
    assign i_sel        = i_sel_reg;
    assign x_sel        = x_sel_reg;
    assign y_sel        = y_sel_reg;
    assign ir_nibble    = DW'(ir_reg[3:0]);
    assign jmp_addr_big = {ir_reg[1:0], y0, x0};

`ifdef ID_DEBUG_EN
    assign dbg_reg_en = reg_en_reg[7:0];
`else
    assign dbg_reg_en = 8'h00;
`endif

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_instr_decoder_pipe
//   Directed vectors followed by randomized traffic, checked against a
//   queue-based reference model of the buffer and decode register and an
//   opcode-class decoder written from the instruction-set rules.
// ---------------------------------------------------------------------------
module tb_instr_decoder_pipe;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            sync_reset;
    logic [7:0]      instr_in;
    logic            instr_valid;
    logic            instr_ready;
    logic            stall;
    logic            flush;
    logic [DW-1:0]   x0, y0;
    logic            dec_valid;
    logic [7:0]      ir;
    logic [DW-1:0]   ir_nibble;
    logic [2*DW+1:0] jmp_addr_big;
    logic            jmp, jmp_nz, i_sel, x_sel, y_sel;
    logic [3:0]      source_sel;
    logic [8:0]      reg_en;
    logic [3:0]      nop_flags;
    logic [CW-1:0]   fifo_count;
    logic [7:0]      dbg_reg_en;

    instr_decoder_pipe #(.DW(DW), .IBUF_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall        (stall),
        .flush        (flush),
        .x0           (x0),
        .y0           (y0),
        .dec_valid    (dec_valid),
        .ir           (ir),
        .ir_nibble    (ir_nibble),
        .jmp_addr_big (jmp_addr_big),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .i_sel        (i_sel),
        .x_sel        (x_sel),
        .y_sel        (y_sel),
        .source_sel   (source_sel),
        .reg_en       (reg_en),
        .nop_flags    (nop_flags),
        .fifo_count   (fifo_count),
        .dbg_reg_en   (dbg_reg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // ---------------- reference model state ----------------
    logic [7:0] q_m[$];
    logic [7:0] ir_m;
    bit         dv_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        ir_m = 8'h00;
        dv_m = 1'b0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit ready_m;
        ready_m = (q_m.size() < DEPTH);
        if (flush) begin
            q_m.delete();
            dv_m = 1'b0;
        end else begin
            if (!stall) begin
                if (q_m.size() > 0) begin
                    ir_m = q_m.pop_front();
                    dv_m = 1'b1;
                end else begin
                    dv_m = 1'b0;
                end
            end
            if (instr_valid && ready_m) q_m.push_back(instr_in);
        end
    endtask

    // Expected decodes, derived from the instruction classes.
    logic [8:0] e_reg_en;
    logic [3:0] e_src, e_nop;
    logic       e_jmp, e_jnz, e_isel, e_xsel, e_ysel;

    task automatic expect_decode(input logic [7:0] i, input bit dv);
        bit is_load, is_mov, is_alu;
        int dst, src, e;
        e_reg_en = 9'h000; e_src = 4'd10; e_nop = 4'h0;
        e_jmp = 0; e_jnz = 0; e_isel = 0; e_xsel = 0; e_ysel = 0;
        if (dv) begin
            is_load = (i < 8'h80);
            is_mov  = (i >= 8'h80) && (i < 8'hC0);
            is_alu  = (i >= 8'hC0) && (i < 8'hE0);
            dst     = is_load ? int'(i >> 4) : int'((i >> 3) & 8'h07);
            src     = int'(i & 8'h07);
            e_jmp   = (i >= 8'hE0) && (i < 8'hF0);
            e_jnz   = (i >= 8'hF0);
            if (is_alu) begin
                e_xsel = i[4];
                e_ysel = i[3];
            end
            if (is_load)                             e_src = 4'd8;
            else if (is_mov && src == 4 && dst == 4) e_src = 4'd4;
            else if (is_mov && src == dst)           e_src = 4'd9;
            else                                     e_src = 4'(src);
            e_isel = !((is_load || is_mov) && dst == 6);
            e = 0;
            if (is_load || is_mov) begin
                if (dst == 0 || dst == 1 || dst == 2 || dst == 3 || dst == 5 || dst == 7)
                    e = e | (1 << dst);
                if (dst == 4) e = e | 256;
                if (dst == 6 || dst == 7) e = e | 64;
            end
            if (is_mov && src == 7) e = e | 64;
            if (is_alu) e = e | 16;
            e_reg_en = 9'(e);
            case (i)
                8'hC8:   e_nop = 4'b0001;
                8'hCF:   e_nop = 4'b0010;
                8'hD8:   e_nop = 4'b0100;
                8'hDF:   e_nop = 4'b1000;
                default: e_nop = 4'b0000;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_dbg;
        expect_decode(ir_m, dv_m);
`ifdef ID_DEBUG_EN
        e_dbg = e_reg_en[7:0];
`else
        e_dbg = 8'h00;
`endif
        check_val({tag, "/fifo_count"}, 32'(fifo_count), 32'(q_m.size()));
        check_val({tag, "/instr_ready"}, 32'(instr_ready), 32'(q_m.size() < DEPTH));
        check_val({tag, "/dec_valid"}, 32'(dec_valid), 32'(dv_m));
        check_val({tag, "/ir"}, 32'(ir), 32'(ir_m));
        check_val({tag, "/ir_nibble"}, 32'(ir_nibble), 32'(ir_m & 8'h0F));
        check_val({tag, "/jmp_addr_big"}, 32'(jmp_addr_big),
                  (32'(ir_m & 8'h03) << (2 * DW)) | (32'(y0) << DW) | 32'(x0));
        check_val({tag, "/jmp"}, 32'(jmp), 32'(e_jmp));
        check_val({tag, "/jmp_nz"}, 32'(jmp_nz), 32'(e_jnz));
        check_val({tag, "/i_sel"}, 32'(i_sel), 32'(e_isel));
        check_val({tag, "/x_sel"}, 32'(x_sel), 32'(e_xsel));
        check_val({tag, "/y_sel"}, 32'(y_sel), 32'(e_ysel));
        check_val({tag, "/source_sel"}, 32'(source_sel), 32'(e_src));
        check_val({tag, "/reg_en"}, 32'(reg_en), 32'(e_reg_en));
        check_val({tag, "/nop_flags"}, 32'(nop_flags), 32'(e_nop));
        check_val({tag, "/dbg_reg_en"}, 32'(dbg_reg_en), 32'(e_dbg));
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "/fifo_count"}, 32'(fifo_count), 32'd0);
        check_val({tag, "/instr_ready"}, 32'(instr_ready), 32'd1);
        check_val({tag, "/dec_valid"}, 32'(dec_valid), 32'd0);
        check_val({tag, "/ir"}, 32'(ir), 32'h00);
        check_val({tag, "/reg_en"}, 32'(reg_en), 32'h1FF);
        check_val({tag, "/source_sel"}, 32'(source_sel), 32'd10);
        check_val({tag, "/jmp_bits"}, {28'd0, jmp, jmp_nz, i_sel, x_sel}, 32'd0);
        check_val({tag, "/y_sel"}, 32'(y_sel), 32'd0);
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit st, input bit fl);
        instr_valid = v;
        instr_in    = d;
        stall       = st;
        flush       = fl;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        n_txn++;
        $display("txn %0d %s: valid=%0b in=%02h stall=%0b flush=%0b -> dv=%0b ir=%02h cnt=%0d",
                 n_txn, tag, instr_valid, instr_in, stall, flush, dv_m, ir_m, q_m.size());
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [7:0] order_vals [5];
    logic [7:0] pick_vals  [10];

    initial begin
        order_vals = '{8'h12, 8'h9B, 8'hC8, 8'hF3, 8'h77};
        pick_vals  = '{8'hC8, 8'hCF, 8'hD8, 8'hDF, 8'hA4, 8'hBF, 8'hB6, 8'h6A, 8'hE7, 8'h40};
        drive(0, 8'h00, 0, 0);
        x0 = '0; y0 = '0;
        sync_reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");

        // Push 0x35 into an empty buffer: decoded one cycle later.
        @(negedge clk);
        sync_reset = 1'b0;
        drive(1, 8'h35, 0, 0);
        tick("push35");
        drive(0, 8'h00, 0, 0);
        tick("dec35");
        check_val("v35/dec_valid", 32'(dec_valid), 32'd1);
        check_val("v35/reg_en", 32'(reg_en), 32'h008);
        check_val("v35/source_sel", 32'(source_sel), 32'd8);
        check_val("v35/ir_nibble", 32'(ir_nibble), 32'd5);

        // Fill under stall; fifth push refused, order preserved on drain.
        for (int k = 0; k < 5; k++) begin
            drive(1, order_vals[k], 1, 0);
            tick("fill");
            if (k == 3) begin
                check_val("full/fifo_count", 32'(fifo_count), 32'd4);
                check_val("full/instr_ready", 32'(instr_ready), 32'd0);
            end
        end
        check_val("full5/fifo_count", 32'(fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'h00, 0, 0);
            tick("drain");
            check_val("order/ir", 32'(ir), 32'(order_vals[k]));
        end
        tick("empty");
        check_val("idle/source_sel", 32'(source_sel), 32'd10);
        check_val("idle/reg_en", 32'(reg_en), 32'd0);

        // Jump decode and flush.
        drive(1, 8'hE2, 0, 0);
        tick("pushE2");
        drive(1, 8'h11, 0, 0);
        tick("decE2");
        x0 = 4'h3; y0 = 4'hA;
        drive(1, 8'h22, 1, 0);
        tick("holdE2");
        check_val("jE2/jmp", 32'(jmp), 32'd1);
        check_val("jE2/jmp_addr_big", 32'(jmp_addr_big), 32'h2A3);
        drive(1, 8'h33, 1, 1);
        tick("flush");
        check_val("flush/fifo_count", 32'(fifo_count), 32'd0);
        check_val("flush/dec_valid", 32'(dec_valid), 32'd0);

        // mov o_reg,o_reg and mov 7,7.
        drive(1, 8'hA4, 0, 0);
        tick("pushA4");
        drive(1, 8'hBF, 0, 0);
        tick("decA4");
        check_val("A4/source_sel", 32'(source_sel), 32'd4);
        check_val("A4/reg_en8", 32'(reg_en[8]), 32'd1);
        drive(0, 8'h00, 0, 0);
        tick("decBF");
        check_val("BF/source_sel", 32'(source_sel), 32'd9);
        check_val("BF/reg_en", 32'(reg_en), 32'h0C0);

        // Reset between edges with three buffered entries.
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'h50 + 8'(k), 1, 0);
            tick("prefill");
        end
        drive(0, 8'h00, 0, 0);
        #2;
        sync_reset = 1'b1;
        #1;
        model_reset();
        check_reset_state("async_rst");
        @(negedge clk);
        sync_reset = 1'b0;
        tick("post_rst");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? pick_vals[$urandom_range(0, 9)] : 8'($urandom());
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0);
            x0 = DW'($urandom());
            y0 = DW'($urandom());
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_decoder_pipe.md
INSTR_DECODER_PIPE -- requirements
Module: instr_decoder_pipe

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high; the ports are named clk and sync_reset.
REQ-002 Parameters SHALL be, one per line:
- DW, default 4, data-register width.
- IBUF_DEPTH, default 4, instruction-buffer entries; power of 2, range 2..8.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock.
- sync_reset  in  1  asynchronous active-high reset.
- instr_in  in  8  instruction from program memory.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  buffer can accept.
- stall  in  1  hold the decode register.
- flush  in  1  discard buffer and decode register (taken jump).
- x0, y0  in  DW  jump-address operands.
- dec_valid  out  1  ir holds a live instruction.
- ir  out  8  decode register.
- ir_nibble  out  DW  ir[3:0] zero-extended.
- jmp_addr_big  out  2*DW+2  {ir[1:0], y0, x0}.
- jmp, jmp_nz  out  1  jump decodes.
- i_sel, x_sel, y_sel  out  1  operand selects.
- source_sel  out  4  data-bus source.
- reg_en  out  9  register enables; [8] is o_reg.
- nop_flags  out  4  {DF, D8, CF, C8} NOP detects.
- fifo_count  out  $clog2(IBUF_DEPTH)+1  buffer occupancy.
- dbg_reg_en  out  8  debug mirror.

Function
REQ-004 The block SHALL accept a push when instr_valid and instr_ready are both high at a rising edge; instr_ready = (fifo_count < IBUF_DEPTH), from registered count only, so a full buffer refuses push even during a pop.
REQ-005 An advance SHALL occur when stall is low at an edge: a non-empty buffer pops its head into ir and sets dec_valid=1; an empty buffer sets dec_valid=0 and leaves ir unchanged.
REQ-006 When stall is high, ir and dec_valid SHALL hold while pushes continue.
REQ-007 Simultaneous push and pop SHALL leave fifo_count unchanged; there is no bypass, so push-to-dec_valid latency is 1 cycle from an empty buffer, 0 wait states.
REQ-008 flush at an edge SHALL empty the buffer, clear dec_valid, and drop any coincident push; flush has priority over stall.
REQ-009 Read/write pointers SHALL wrap modulo IBUF_DEPTH.
REQ-010 Decodes SHALL apply when dec_valid=1:
- jmp = ir[7:4]==1110; jmp_nz = ir[7:4]==1111.
- x_sel = ir[4] and y_sel = ir[3] when ir[7:5]==110, else 0.
REQ-011 source_sel SHALL be, in priority order:
- 8 for load (ir[7]=0).
- 4 for mov (ir[7:6]=10) with src==dst==4.
- 9 for mov with src==dst.
- {0,ir[2:0]} otherwise.
REQ-012 i_sel SHALL be 0 for load or mov with dst==6, else 1.
REQ-013 reg_en SHALL decode as follows:
- Bits 0,1,2,3,5,7 are set by load with ir[7:4]==k or mov with dst==k.
- Bit 4 is set by ALU (ir[7:5]=110).
- Bit 8 is set by load or mov with dst code 4.
- Bit 6 is set by load or mov with dst 6 or 7, or mov with src 7.
REQ-014 nop_flags SHALL assert for ir equal to C8, CF, D8, DF respectively.
REQ-015 When dec_valid=0 outside reset, the idle outputs SHALL be:
- jmp=jmp_nz=0.
- reg_en=0.
- source_sel=10.
- i_sel=x_sel=y_sel=0.
- nop_flags=0.
REQ-016 ir_nibble and jmp_addr_big SHALL follow ir regardless of dec_valid.

Reset
REQ-017 While sync_reset is high, these SHALL hold:
- Buffer empty, fifo_count=0, instr_ready=1.
- dec_valid=0, ir=00.
- reg_en=9'h1FF, source_sel=10.
- jmp=jmp_nz=i_sel=x_sel=y_sel=0.
REQ-018 Reset asserted mid-operation SHALL discard all buffered instructions immediately, without waiting for a clock edge.

Configuration
REQ-019 With ID_DEBUG_EN defined, dbg_reg_en SHALL equal reg_en[7:0]; without it, dbg_reg_en SHALL be tied to 8'h00 and no mirroring logic is built.

Verification
REQ-020 Reset release then push 0x35 on an empty buffer SHALL give, next cycle: dec_valid=1, reg_en=9'h008, source_sel=8, ir_nibble=5.
REQ-021 With stall held, pushing four instructions SHALL give fifo_count=4 and instr_ready=0; a fifth push SHALL be refused and the FIFO order preserved.
REQ-022 ir=E2 with x0=3, y0=A SHALL give jmp=1 and jmp_addr_big=10'h2A3; flush on the next edge SHALL clear fifo_count and dec_valid.
REQ-023 ir=0xA4 (mov o_reg,o_reg) SHALL give source_sel=4 and reg_en[8]=1; ir=0xBF SHALL give source_sel=9 and reg_en=9'h0C0.
REQ-024 sync_reset asserted between edges with 3 entries buffered SHALL give fifo_count=0 and reg_en=9'h1FF immediately.
